// File: rtl/adpll_loop_ctrl.sv
// ADPLL/CDR loop controller: counter-based signed phase detector, shift-gain
// PI filter with saturating integrator, and a lock detector.
module adpll_loop_ctrl #(
  parameter int ERR_W   = 8,
  parameter int CTRL_W  = 10,
  parameter int FRAC_W  = 4,
  parameter int GAIN_W  = 4,
  parameter int LOCK_CW = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               ref_edge,
  input  logic               fb_edge,
  input  logic [GAIN_W-1:0]  alpha_sh,
  input  logic [GAIN_W-1:0]  beta_sh,
  input  logic [ERR_W-2:0]   lock_tol,
  input  logic [LOCK_CW-1:0] lock_cnt,
  output logic [ERR_W-1:0]   phase_err,
  output logic               err_valid,
  output logic [CTRL_W-1:0]  ctrl_word,
  output logic               ctrl_valid,
  output logic               locked,
  output logic               lock_lost
);

  localparam int ACC_W = CTRL_W + FRAC_W;
  localparam logic [ERR_W-2:0]   CNT_MAX  = '1;
  localparam logic [ERR_W-2:0]   CNT_ONE  = 1;
  localparam logic [LOCK_CW-1:0] LOCK_ONE = 1;
  localparam logic [ACC_W-1:0]   ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0]   ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {PD_IDLE, PD_REF_LEAD, PD_FB_LEAD} pd_state_t;
  typedef enum logic [1:0] {LK_UNLOCKED, LK_LOCKING, LK_LOCKED} lk_state_t;

  pd_state_t          pd_state;
  lk_state_t          lk_state;
  logic [ERR_W-2:0]   cnt;
  logic               start;
  logic               err_slip;
  logic [ACC_W-1:0]   integ;
  logic [LOCK_CW-1:0] lcnt;

  // Feedback edges are meaningless until the reference has been seen once.
  logic             fb_qual;
  logic [ERR_W-2:0] cnt_inc;
  logic [ERR_W-1:0] err_pos;
  logic [ERR_W-1:0] err_neg;
  logic [ERR_W-1:0] err_max_pos;
  logic [ERR_W-1:0] err_max_neg;

  assign fb_qual     = fb_edge & start;
  assign cnt_inc     = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_ONE;
  assign err_pos     = {1'b0, cnt_inc};
  assign err_neg     = '0 - err_pos;
  assign err_max_pos = {1'b0, CNT_MAX};
  assign err_max_neg = '0 - err_max_pos;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pd_state  <= PD_IDLE;
      cnt       <= '0;
      start     <= 1'b0;
      phase_err <= '0;
      err_valid <= 1'b0;
      err_slip  <= 1'b0;
    end else if (clr) begin
      pd_state  <= PD_IDLE;
      cnt       <= '0;
      start     <= 1'b0;
      phase_err <= '0;
      err_valid <= 1'b0;
      err_slip  <= 1'b0;
    end else begin
      err_valid <= 1'b0;
      err_slip  <= 1'b0;
      if (ref_edge) start <= 1'b1;
      case (pd_state)
        PD_IDLE: begin
          if (ref_edge && fb_qual) begin
            phase_err <= '0;
            err_valid <= 1'b1;
          end else if (ref_edge) begin
            pd_state <= PD_REF_LEAD;
            cnt      <= '0;
          end else if (fb_qual) begin
            pd_state <= PD_FB_LEAD;
            cnt      <= '0;
          end
        end
        PD_REF_LEAD: begin
          if (fb_qual) begin
            phase_err <= err_pos;
            err_valid <= 1'b1;
            cnt       <= '0;
            pd_state  <= ref_edge ? PD_REF_LEAD : PD_IDLE;
          end else if (ref_edge) begin
            phase_err <= err_max_pos;
            err_valid <= 1'b1;
            err_slip  <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        PD_FB_LEAD: begin
          if (ref_edge) begin
            phase_err <= err_neg;
            err_valid <= 1'b1;
            cnt       <= '0;
            pd_state  <= fb_qual ? PD_FB_LEAD : PD_IDLE;
          end else if (fb_qual) begin
            phase_err <= err_max_neg;
            err_valid <= 1'b1;
            err_slip  <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: pd_state <= PD_IDLE;
      endcase
    end
  end

  function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W:0] v);
    if (v[ACC_W] != v[ACC_W-1]) sat_acc = v[ACC_W] ? ACC_MIN : ACC_MAX;
    else                        sat_acc = v[ACC_W-1:0];
  endfunction

  // Error scaled into accumulator units; arithmetic shifts floor toward -inf.
  logic [ACC_W-1:0] e_sx;
  logic [ACC_W-1:0] e_int;
  logic [ACC_W-1:0] e_prop;
  logic [ACC_W:0]   integ_sum;
  logic [ACC_W-1:0] integ_new;
  logic [ACC_W:0]   filt_sum;
  logic [ACC_W-1:0] filt;

  assign e_sx      = {{(ACC_W-ERR_W){phase_err[ERR_W-1]}}, phase_err} << FRAC_W;
  assign e_int     = $signed(e_sx) >>> alpha_sh;
  assign e_prop    = $signed(e_sx) >>> beta_sh;
  assign integ_sum = {integ[ACC_W-1], integ} + {e_int[ACC_W-1], e_int};
  assign integ_new = (alpha_sh == '1) ? integ : sat_acc(integ_sum);
  assign filt_sum  = {integ_new[ACC_W-1], integ_new} + {e_prop[ACC_W-1], e_prop};
  assign filt      = sat_acc(filt_sum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integ      <= '0;
      ctrl_word  <= '0;
      ctrl_valid <= 1'b0;
    end else if (clr) begin
      integ      <= '0;
      ctrl_word  <= '0;
      ctrl_valid <= 1'b0;
    end else begin
      ctrl_valid <= err_valid;
      if (err_valid) begin
        integ     <= integ_new;
        ctrl_word <= filt[ACC_W-1:FRAC_W];
      end
    end
  end

  logic [ERR_W-1:0]   err_abs;
  logic               in_tol;
  logic [LOCK_CW-1:0] lock_need;
  logic [LOCK_CW-1:0] lcnt_inc;

  assign err_abs   = phase_err[ERR_W-1] ? ('0 - phase_err) : phase_err;
  assign in_tol    = !err_slip && (err_abs <= {1'b0, lock_tol});
  assign lock_need = (lock_cnt == '0) ? LOCK_ONE : lock_cnt;
  assign lcnt_inc  = lcnt + LOCK_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_state  <= LK_UNLOCKED;
      lcnt      <= '0;
      locked    <= 1'b0;
      lock_lost <= 1'b0;
    end else if (clr) begin
      lk_state  <= LK_UNLOCKED;
      lcnt      <= '0;
      locked    <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      lock_lost <= 1'b0;
      if (err_valid) begin
        case (lk_state)
          LK_UNLOCKED: begin
            if (in_tol) begin
              lcnt <= LOCK_ONE;
              if (lock_need <= LOCK_ONE) begin
                lk_state <= LK_LOCKED;
                locked   <= 1'b1;
              end else begin
                lk_state <= LK_LOCKING;
              end
            end
          end
          LK_LOCKING: begin
            if (in_tol) begin
              lcnt <= lcnt_inc;
              // >= so a live reduction of lock_cnt still completes the lock.
              if (lcnt_inc >= lock_need) begin
                lk_state <= LK_LOCKED;
                locked   <= 1'b1;
              end
            end else begin
              lk_state <= LK_UNLOCKED;
              lcnt     <= '0;
            end
          end
          LK_LOCKED: begin
            if (!in_tol) begin
              lk_state  <= LK_UNLOCKED;
              lcnt      <= '0;
              locked    <= 1'b0;
              lock_lost <= 1'b1;
            end
          end
          default: lk_state <= LK_UNLOCKED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adpll_loop_ctrl.sv
// Bench for adpll_loop_ctrl: timestamp-based reference model feeds expected
// queues; a monitor pops and compares whenever the DUT strobes an output.
module tb_adpll_loop_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       ref_edge = 1'b0;
  logic       fb_edge = 1'b0;
  logic [3:0] alpha_sh = '0;
  logic [3:0] beta_sh = '0;
  logic [6:0] lock_tol = '0;
  logic [5:0] lock_cnt = '0;
  logic [7:0] phase_err;
  logic       err_valid;
  logic [9:0] ctrl_word;
  logic       ctrl_valid;
  logic       locked;
  logic       lock_lost;

  adpll_loop_ctrl dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .ref_edge(ref_edge), .fb_edge(fb_edge),
    .alpha_sh(alpha_sh), .beta_sh(beta_sh),
    .lock_tol(lock_tol), .lock_cnt(lock_cnt),
    .phase_err(phase_err), .err_valid(err_valid),
    .ctrl_word(ctrl_word), .ctrl_valid(ctrl_valid),
    .locked(locked), .lock_lost(lock_lost)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_hold = 1'b1;

  logic [7:0] exp_err_q[$];
  logic [9:0] exp_ctrl_q[$];
  logic [1:0] exp_lock_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: edge timestamps, integer PI arithmetic, streak counting
  int m_lead = 0;
  int m_t0 = 0;
  bit m_started = 0;
  int m_integ = 0;
  bit m_locked = 0;
  int m_streak = 0;
  int cyc_n = 0;

  function automatic int floor_div(int v, int s);
    int d = 1 << s;
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);
  endfunction

  function automatic int clamp_acc(int v);
    if (v > 8191) return 8191;
    if (v < -8192) return -8192;
    return v;
  endfunction

  function automatic int sat_err(int v);
    return (v > 127) ? 127 : v;
  endfunction

  task automatic emit(input int err, input bit slip);
    int e, filt, need, mag;
    bit tol, lost;
    exp_err_q.push_back(8'(err));
    e = err * 16;
    if (alpha_sh != 4'hF) m_integ = clamp_acc(m_integ + floor_div(e, int'(alpha_sh)));
    filt = clamp_acc(m_integ + floor_div(e, int'(beta_sh)));
    exp_ctrl_q.push_back(10'(floor_div(filt, 4)));
    need = (lock_cnt == 0) ? 1 : int'(lock_cnt);
    mag  = (err < 0) ? -err : err;
    tol  = !slip && (mag <= int'(lock_tol));
    lost = 1'b0;
    if (tol) begin
      m_streak++;
      if (m_streak >= need) m_locked = 1'b1;
    end else begin
      lost = m_locked;
      m_locked = 1'b0;
      m_streak = 0;
    end
    exp_lock_q.push_back({m_locked, lost});
  endtask

  task automatic model_step(input bit r, input bit f);
    bit fv = f && m_started;
    case (m_lead)
      0: begin
        if (r && fv) emit(0, 0);
        else if (r)  begin m_lead = 1; m_t0 = cyc_n; end
        else if (fv) begin m_lead = 2; m_t0 = cyc_n; end
      end
      1: begin
        if (fv) begin
          emit(sat_err(cyc_n - m_t0), 0);
          if (r) m_t0 = cyc_n; else m_lead = 0;
        end else if (r) begin
          emit(127, 1);
          m_t0 = cyc_n;
        end
      end
      default: begin
        if (r) begin
          emit(-sat_err(cyc_n - m_t0), 0);
          if (fv) m_t0 = cyc_n; else m_lead = 0;
        end else if (fv) begin
          emit(-127, 1);
          m_t0 = cyc_n;
        end
      end
    endcase
    if (r) m_started = 1'b1;
    cyc_n++;
  endtask

  task automatic model_reset();
    m_lead = 0; m_started = 0; m_integ = 0; m_locked = 0; m_streak = 0;
    exp_err_q.delete(); exp_ctrl_q.delete(); exp_lock_q.delete();
  endtask

  // driver tasks: called at a negedge, return at the next negedge
  task automatic cyc(input bit r, input bit f);
    ref_edge = r;
    fb_edge  = f;
    model_step(r, f);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0);
  endtask

  function automatic int out_bits();
    return int'({phase_err, err_valid, ctrl_word, ctrl_valid, locked, lock_lost});
  endfunction

  task automatic do_reset(input bit use_clr);
    mon_hold = 1'b1;
    idle(3);
    if (use_clr) begin
      clr = 1'b1;
      cyc(0, 0);
      clr = 1'b0;
      chk("clr_outputs", out_bits(), 0);
    end else begin
      rst_n = 1'b0;
      #1;
      chk("rst_outputs", out_bits(), 0);
      @(negedge clk);
      rst_n = 1'b1;
    end
    model_reset();
    idle(2);
    mon_hold = 1'b0;
  endtask

  // scoreboard monitor
  logic [9:0] last_ctrl = '0;
  logic       last_locked = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_hold) begin
        last_ctrl   = '0;
        last_locked = 1'b0;
      end else begin
        if (err_valid) begin
          chk("err_expected", int'(exp_err_q.size() > 0), 1);
          if (exp_err_q.size() > 0) chk("phase_err", int'(phase_err), int'(exp_err_q.pop_front()));
        end
        if (ctrl_valid) begin
          chk("ctrl_expected", int'(exp_ctrl_q.size() > 0), 1);
          if (exp_ctrl_q.size() > 0) begin
            chk("ctrl_word", int'(ctrl_word), int'(exp_ctrl_q.pop_front()));
            chk("lock_state", int'({locked, lock_lost}), int'(exp_lock_q.pop_front()));
          end
          last_ctrl   = ctrl_word;
          last_locked = locked;
        end else begin
          chk("hold_outputs", int'({ctrl_word, locked, lock_lost}),
              int'({last_ctrl, last_locked, 1'b0}));
        end
      end
    end
  end

  initial begin
    int p;
    repeat (3) @(negedge clk);
    chk("reset_outputs", out_bits(), 0);
    rst_n = 1'b1;
    idle(2);
    mon_hold = 1'b0;

    // T1: ref leads fb by 5 with unity gains
    lock_cnt = 6'd4;
    cyc(1, 0); idle(4); cyc(0, 1);
    chk("t1_err_valid", int'(err_valid), 1);
    chk("t1_phase_err", int'($signed(phase_err)), 5);
    cyc(0, 0);
    chk("t1_ctrl_valid", int'(ctrl_valid), 1);
    chk("t1_ctrl_word", int'($signed(ctrl_word)), 10);

    // T2: coincident edges, zero error leaves integrator at 80
    idle(3); cyc(1, 1);
    chk("t2_phase_err", int'($signed(phase_err)), 0);
    cyc(0, 0);
    chk("t2_ctrl_word", int'($signed(ctrl_word)), 5);

    // T3: fb leads ref by 3
    idle(3); cyc(0, 1); idle(2); cyc(1, 0);
    chk("t3_phase_err", int'($signed(phase_err)), -3);
    cyc(0, 0);
    chk("t3_ctrl_word", int'($signed(ctrl_word)), -1);

    // T4: slips saturate the error and then the control word
    idle(3); cyc(1, 0); idle(199); cyc(1, 0);
    chk("t4_slip_err", int'($signed(phase_err)), 127);
    for (int i = 0; i < 6; i++) begin idle(4); cyc(1, 0); end
    cyc(0, 0);
    chk("t4_ctrl_sat", int'($signed(ctrl_word)), 511);

    // T5: lock after four in-tolerance errors, then lose it
    do_reset(1);
    lock_tol = 7'd1; lock_cnt = 6'd4;
    cyc(1, 0); idle(2); cyc(0, 1);
    idle(3); cyc(1, 1);
    idle(3); cyc(1, 0); cyc(0, 1);
    idle(3); cyc(0, 1); cyc(1, 0);
    idle(3); cyc(1, 1);
    chk("t5_not_yet_locked", int'(locked), 0);
    cyc(0, 0);
    chk("t5_locked", int'(locked), 1);
    idle(3); cyc(1, 0); idle(5); cyc(0, 1);
    cyc(0, 0);
    chk("t5_lock_lost", int'({locked, lock_lost}), 1);
    cyc(0, 0);
    chk("t5_lost_pulse", int'(lock_lost), 0);

    // T6: async reset mid REF_LEAD, then fb alone must not produce errors
    idle(3); cyc(1, 0);
    do_reset(0);
    cyc(0, 1);
    chk("t6_no_err", int'(err_valid), 0);
    idle(3); cyc(0, 1); idle(3);

    // randomized blocks with live parameter changes between them
    for (int b = 0; b < 40; b++) begin
      alpha_sh = 4'($urandom_range(0, 15));
      beta_sh  = 4'($urandom_range(0, 15));
      lock_tol = 7'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 8));
      lock_cnt = 6'($urandom_range(0, 7));
      p = (b % 8 == 7) ? 1 : $urandom_range(2, 25);
      for (int i = 0; i < 60; i++)
        cyc($urandom_range(0, 99) < p, $urandom_range(0, 99) < p);
      idle(4);
      if (b % 10 == 9) do_reset(b % 20 == 19 ? 1'b0 : 1'b1);
    end

    idle(10);
    chk("drain_err_q", exp_err_q.size(), 0);
    chk("drain_ctrl_q", exp_ctrl_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
